// File: rtl/execute_arbiter.sv
// execute_arbiter: shares one combinational Execute stage between two
// requesters. The winning operand set is latched and driven into Execute for
// one cycle. The result is then returned on a valid/ready response channel
// tagged with the requester id.
//
// Build option: define EXEC_ARB_FIXED_PRIO_EN to make requester 0 win every
// contention. In that build the round-robin pointer is removed. When the
// macro is undefined the arbiter is round-robin.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | arbitrate; a grant latches the winner's operands into out_exe_*
// EXEC  | Execute sees the latched operands; result is captured at the edge
// RESP  | response held valid until the consumer accepts it

module execute_arbiter #(
  parameter int DATA_W = 16,
  parameter int FUNC_W = 4,
  parameter int OP_W   = 2
) (
  input  logic              inp_clk,
  input  logic              inp_rst_n,
  input  logic [1:0]        inp_req_valid,
  output logic [1:0]        out_req_ready,
  input  logic              inp_req0_aluSrc,
  input  logic [OP_W-1:0]   inp_req0_aluOp,
  input  logic [FUNC_W-1:0] inp_req0_func,
  input  logic [DATA_W-1:0] inp_req0_data1,
  input  logic [DATA_W-1:0] inp_req0_data2,
  input  logic [DATA_W-1:0] inp_req0_imm,
  input  logic              inp_req1_aluSrc,
  input  logic [OP_W-1:0]   inp_req1_aluOp,
  input  logic [FUNC_W-1:0] inp_req1_func,
  input  logic [DATA_W-1:0] inp_req1_data1,
  input  logic [DATA_W-1:0] inp_req1_data2,
  input  logic [DATA_W-1:0] inp_req1_imm,
  output logic              out_exe_aluSrc,
  output logic [OP_W-1:0]   out_exe_aluOp,
  output logic [FUNC_W-1:0] out_exe_func,
  output logic [DATA_W-1:0] out_exe_data1,
  output logic [DATA_W-1:0] out_exe_data2,
  output logic [DATA_W-1:0] out_exe_imm,
  input  logic [DATA_W-1:0] inp_exe_result,
  input  logic              inp_exe_zero,
  output logic              out_rsp_valid,
  input  logic              inp_rsp_ready,
  output logic              out_rsp_id,
  output logic [DATA_W-1:0] out_rsp_result,
  output logic              out_rsp_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                exe_alu_src_q, exe_alu_src_d;
  logic [OP_W-1:0]     exe_alu_op_q, exe_alu_op_d;
  logic [FUNC_W-1:0]   exe_func_q, exe_func_d;
  logic [DATA_W-1:0]   exe_data1_q, exe_data1_d;
  logic [DATA_W-1:0]   exe_data2_q, exe_data2_d;
  logic [DATA_W-1:0]   exe_imm_q, exe_imm_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
`ifndef EXEC_ARB_FIXED_PRIO_EN
  logic                ptr_q, ptr_d;
`endif

  logic [1:0] req_ready;
  logic       grant;
  logic       winner;

  // Accept is only offered in IDLE; contention is resolved by pointer or fixed priority.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == ST_IDLE) begin
      case (inp_req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
`ifdef EXEC_ARB_FIXED_PRIO_EN
        2'b11:   req_ready = 2'b01;
`else
        2'b11:   req_ready = ptr_q ? 2'b10 : 2'b01;
`endif
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign grant  = |(inp_req_valid & req_ready);
  assign winner = req_ready[1];

  // Next-state and next-output computation for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d       = state_q;
    exe_alu_src_d = exe_alu_src_q;
    exe_alu_op_d  = exe_alu_op_q;
    exe_func_d    = exe_func_q;
    exe_data1_d   = exe_data1_q;
    exe_data2_d   = exe_data2_q;
    exe_imm_d     = exe_imm_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
`ifndef EXEC_ARB_FIXED_PRIO_EN
    ptr_d         = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          if (winner) begin
            exe_alu_src_d = inp_req1_aluSrc;
            exe_alu_op_d  = inp_req1_aluOp;
            exe_func_d    = inp_req1_func;
            exe_data1_d   = inp_req1_data1;
            exe_data2_d   = inp_req1_data2;
            exe_imm_d     = inp_req1_imm;
          end else begin
            exe_alu_src_d = inp_req0_aluSrc;
            exe_alu_op_d  = inp_req0_aluOp;
            exe_func_d    = inp_req0_func;
            exe_data1_d   = inp_req0_data1;
            exe_data2_d   = inp_req0_data2;
            exe_imm_d     = inp_req0_imm;
          end
          rsp_id_d = winner;
`ifndef EXEC_ARB_FIXED_PRIO_EN
          ptr_d    = ~winner;
`endif
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = inp_exe_result;
        rsp_zero_d   = inp_exe_zero;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (inp_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Single state register; reset discards any in-flight response.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_q       <= ST_IDLE;
      exe_alu_src_q <= 1'b0;
      exe_alu_op_q  <= '0;
      exe_func_q    <= '0;
      exe_data1_q   <= '0;
      exe_data2_q   <= '0;
      exe_imm_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
`ifndef EXEC_ARB_FIXED_PRIO_EN
      ptr_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      exe_alu_src_q <= exe_alu_src_d;
      exe_alu_op_q  <= exe_alu_op_d;
      exe_func_q    <= exe_func_d;
      exe_data1_q   <= exe_data1_d;
      exe_data2_q   <= exe_data2_d;
      exe_imm_q     <= exe_imm_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
`ifndef EXEC_ARB_FIXED_PRIO_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign out_req_ready  = req_ready;
  assign out_exe_aluSrc = exe_alu_src_q;
  assign out_exe_aluOp  = exe_alu_op_q;
  assign out_exe_func   = exe_func_q;
  assign out_exe_data1  = exe_data1_q;
  assign out_exe_data2  = exe_data2_q;
  assign out_exe_imm    = exe_imm_q;
  assign out_rsp_valid  = rsp_valid_q;
  assign out_rsp_id     = rsp_id_q;
  assign out_rsp_result = rsp_result_q;
  assign out_rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_execute_arbiter.sv
// Directed bench for execute_arbiter. Inputs change 1 time unit after the
// rising edge, and outputs are sampled a further time unit later.
// The Execute stage is a stub that returns whatever result and zero values
// each test loads.
`timescale 1ns/1ps

module tb_execute_arbiter;

  localparam int DATA_W = 16;
  localparam int FUNC_W = 4;
  localparam int OP_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_ready;
  logic              r0_src = 1'b0, r1_src = 1'b0;
  logic [OP_W-1:0]   r0_op = '0, r1_op = '0;
  logic [FUNC_W-1:0] r0_func = '0, r1_func = '0;
  logic [DATA_W-1:0] r0_d1 = '0, r0_d2 = '0, r0_imm = '0;
  logic [DATA_W-1:0] r1_d1 = '0, r1_d2 = '0, r1_imm = '0;
  logic              exe_src;
  logic [OP_W-1:0]   exe_op;
  logic [FUNC_W-1:0] exe_func;
  logic [DATA_W-1:0] exe_d1, exe_d2, exe_imm;
  logic [DATA_W-1:0] stub_result = '0;
  logic              stub_zero = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;

  int n_checks = 0;
  int n_pass   = 0;

  execute_arbiter #(.DATA_W(DATA_W), .FUNC_W(FUNC_W), .OP_W(OP_W)) dut (
    .inp_clk         (clk),
    .inp_rst_n       (rst_n),
    .inp_req_valid   (req_valid),
    .out_req_ready   (req_ready),
    .inp_req0_aluSrc (r0_src),
    .inp_req0_aluOp  (r0_op),
    .inp_req0_func   (r0_func),
    .inp_req0_data1  (r0_d1),
    .inp_req0_data2  (r0_d2),
    .inp_req0_imm    (r0_imm),
    .inp_req1_aluSrc (r1_src),
    .inp_req1_aluOp  (r1_op),
    .inp_req1_func   (r1_func),
    .inp_req1_data1  (r1_d1),
    .inp_req1_data2  (r1_d2),
    .inp_req1_imm    (r1_imm),
    .out_exe_aluSrc  (exe_src),
    .out_exe_aluOp   (exe_op),
    .out_exe_func    (exe_func),
    .out_exe_data1   (exe_d1),
    .out_exe_data2   (exe_d2),
    .out_exe_imm     (exe_imm),
    .inp_exe_result  (stub_result),
    .inp_exe_zero    (stub_zero),
    .out_rsp_valid   (rsp_valid),
    .inp_rsp_ready   (rsp_ready),
    .out_rsp_id      (rsp_id),
    .out_rsp_result  (rsp_result),
    .out_rsp_zero    (rsp_zero)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  logic [1:0] exp_rdy [4];
  logic [DATA_W-1:0] exp_d1;

  initial begin
`ifdef EXEC_ARB_FIXED_PRIO_EN
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b01;
`else
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
`endif

    // ---- reset values
    do_reset();
    check_eq("rst_ready", {30'd0, req_ready}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check_eq("rst_exe_d1", {16'd0, exe_d1}, 32'd0);

    // ---- single request
    r0_src = 1'b0; r0_op = 2'd2; r0_func = 4'd1; r0_d1 = 16'd4; r0_d2 = 16'd3; r0_imm = 16'd2;
    stub_result = 16'h0007; stub_zero = 1'b0; rsp_ready = 1'b1;
    req_valid = 2'b01;
    #1;
    check_eq("single_ready", {30'd0, req_ready}, 32'h1);
    step();
    req_valid = 2'b00;
    #1;
    check_eq("single_exec_ready", {30'd0, req_ready}, 32'h0);
    check_eq("single_exe_fields", {exe_src, exe_op, exe_func, exe_d1[7:0], exe_d2[7:0], exe_imm[7:0]},
             {1'b0, 2'd2, 4'd1, 8'd4, 8'd3, 8'd2});
    check_eq("single_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    check_eq("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("single_rsp_id", {31'd0, rsp_id}, 32'd0);
    check_eq("single_rsp_result", {16'd0, rsp_result}, 32'h0007);
    check_eq("single_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    step();
    check_eq("single_back_idle", {31'd0, rsp_valid}, 32'd0);

    // ---- contention from reset: both valid continuously
    do_reset();
    r0_d1 = 16'h0010; r1_d1 = 16'h0020;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_d1 = exp_rdy[k][1] ? 16'h0020 : 16'h0010;
      check_eq($sformatf("cont_ready_%0d", k), {30'd0, req_ready}, {30'd0, exp_rdy[k]});
      step();
      check_eq($sformatf("cont_exec_ready_%0d", k), {30'd0, req_ready}, 32'd0);
      check_eq($sformatf("cont_exe_d1_%0d", k), {16'd0, exe_d1}, {16'd0, exp_d1});
      step();
      check_eq($sformatf("cont_rsp_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
      check_eq($sformatf("cont_rsp_id_%0d", k), {31'd0, rsp_id}, {31'd0, exp_rdy[k][1]});
      check_eq($sformatf("cont_resp_ready_%0d", k), {30'd0, req_ready}, 32'd0);
      step();
    end

    // ---- backpressure: response held for 5 cycles
    do_reset();
    rsp_ready = 1'b0;
    stub_result = 16'h0001; stub_zero = 1'b0;
    req_valid = 2'b11;
    #1;
    check_eq("bp_grant_ready", {30'd0, req_ready}, 32'h1);
    step();
    step();
    stub_result = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("bp_rsp_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
      check_eq($sformatf("bp_rsp_result_%0d", k), {16'd0, rsp_result}, 32'h0001);
      check_eq($sformatf("bp_ready_%0d", k), {30'd0, req_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check_eq("bp_released_valid", {31'd0, rsp_valid}, 32'd0);
`ifdef EXEC_ARB_FIXED_PRIO_EN
    check_eq("bp_next_ready", {30'd0, req_ready}, 32'h1);
`else
    check_eq("bp_next_ready", {30'd0, req_ready}, 32'h2);
`endif

    // ---- zero flag passthrough
    stub_result = 16'h0000; stub_zero = 1'b1;
    step();
    req_valid = 2'b00;
    step();
    check_eq("zero_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("zero_rsp_zero", {31'd0, rsp_zero}, 32'd1);
    check_eq("zero_rsp_result", {16'd0, rsp_result}, 32'h0000);
`ifdef EXEC_ARB_FIXED_PRIO_EN
    check_eq("zero_rsp_id", {31'd0, rsp_id}, 32'd0);
`else
    check_eq("zero_rsp_id", {31'd0, rsp_id}, 32'd1);
`endif
    step();

    // ---- asynchronous reset in EXEC
    r0_op = 2'd3; r0_d1 = 16'h0010;
    stub_result = 16'h00AA; stub_zero = 1'b0;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check_eq("rstx_in_exec_d1", {16'd0, exe_d1}, 32'h0010);
    rst_n = 1'b0;
    #1;
    check_eq("rstx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rstx_exe_d1", {16'd0, exe_d1}, 32'd0);
    check_eq("rstx_exe_op", {30'd0, exe_op}, 32'd0);
    check_eq("rstx_ready", {30'd0, req_ready}, 32'd0);
    step();
    check_eq("rstx_still_idle", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    req_valid = 2'b10;
    #1;
    check_eq("rstx_req1_ready", {30'd0, req_ready}, 32'h2);
    step();
    req_valid = 2'b00;
    check_eq("rstx_req1_exe_d1", {16'd0, exe_d1}, 32'h0020);
    step();
    check_eq("rstx_req1_rsp_id", {31'd0, rsp_id}, 32'd1);
    check_eq("rstx_req1_result", {16'd0, rsp_result}, 32'h00AA);
    step();
    req_valid = 2'b11;
    #1;
    check_eq("rstx_ptr_zero", {30'd0, req_ready}, 32'h1);
    req_valid = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the bench always ends even if the sequence above stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
